// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared state and wait-code encodings for the ID-stage branch sequencer
package branch_pkg;

    typedef enum logic [1:0] {
        BC_IDLE  = 2'd0,
        BC_WAIT  = 2'd1,
        BC_REDIR = 2'd2
    } bc_state_t;

    localparam logic [1:0] WAIT_NONE = 2'd0;
    localparam logic [1:0] WAIT_EX   = 2'd1;
    localparam logic [1:0] WAIT_EC   = 2'd2;

    // Code 3 never comes from a healthy branch unit; fold it onto the longest wait.
    function automatic logic [1:0] wait_norm(input logic [1:0] code);
        return (code == 2'd3) ? WAIT_EC : code;
    endfunction

endpackage

// File: rtl/branch_stat_cnt.sv
// rtl/branch_stat_cnt.sv - wrapping resolution/taken/stall counters for the branch sequencer
module branch_stat_cnt #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc_branch,
    input  logic              inc_taken,
    input  logic              inc_stall,
    output logic [STAT_W-1:0] stat_branch,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_stall
);

    // Free-running counters; overflow wraps to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_branch <= '0;
            stat_taken  <= '0;
            stat_stall  <= '0;
        end else begin
            if (inc_branch) stat_branch <= stat_branch + 1'b1;
            if (inc_taken)  stat_taken  <= stat_taken + 1'b1;
            if (inc_stall)  stat_stall  <= stat_stall + 1'b1;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage branch stall/resolve/redirect sequencer (optional stats: BRANCH_STAT_EN)
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int STAT_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [1:0]      wait_seg,
    input  logic            realj,
    input  logic [PC_W-1:0] target,
    input  logic            ex_flush,
    input  logic            if_redirect_ready,
    output logic            id_stall,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            busy
`ifdef BRANCH_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_branch,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    bc_state_t  state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       br, take, resolve, load_pc, stall;
    logic [1:0] ws_eff;

    assign br     = id_valid & id_branch;
    assign take   = id_jump | realj;
    assign ws_eff = wait_norm(wait_seg);

    // Next-state, stall and resolution decode; ex_flush overrides everything last.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        resolve = 1'b0;
        load_pc = 1'b0;
        case (state)
            BC_IDLE: begin
                if (br) begin
                    if (ws_eff == WAIT_NONE) begin
                        resolve = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_n   = ws_eff - 2'd1;
                        state_n = BC_WAIT;
                    end
                end
            end
            BC_WAIT: begin
                if (cnt != 2'd0) begin
                    stall = 1'b1;
                    cnt_n = cnt - 2'd1;
                end else begin
                    resolve = 1'b1;
                end
            end
            BC_REDIR: begin
                // A branch in the delay slot waits until fetch takes the pending redirect.
                stall = br;
                if (if_redirect_ready) state_n = BC_IDLE;
            end
            default: state_n = BC_IDLE;
        endcase
        if (resolve) begin
            load_pc = take;
            state_n = take ? BC_REDIR : BC_IDLE;
        end
        if (ex_flush) begin
            stall   = 1'b0;
            resolve = 1'b0;
            load_pc = 1'b0;
            cnt_n   = 2'd0;
            state_n = BC_IDLE;
        end
    end

    assign id_stall = stall & resetn;
    assign busy     = (state != BC_IDLE);

    // State, wait counter and the held redirect request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= BC_IDLE;
            cnt            <= 2'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            redirect_valid <= (state_n == BC_REDIR);
            if (load_pc) redirect_pc <= target;
        end
    end

`ifdef BRANCH_STAT_EN
    branch_stat_cnt #(
        .STAT_W(STAT_W)
    ) u_stat (
        .clk        (clk),
        .resetn     (resetn),
        .inc_branch (resolve),
        .inc_taken  (resolve & take),
        .inc_stall  (id_stall),
        .stat_branch(stat_branch),
        .stat_taken (stat_taken),
        .stat_stall (stat_stall)
    );
`else
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed plus random check of branch_ctrl against a cycle-count reference model
module tb_branch_ctrl;

    localparam int PC_W   = 32;
    localparam int STAT_W = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            id_valid = 1'b0, id_branch = 1'b0, id_jump = 1'b0;
    logic [1:0]      wait_seg = 2'd0;
    logic            realj = 1'b0;
    logic [PC_W-1:0] target = '0;
    logic            ex_flush = 1'b0, if_redirect_ready = 1'b0;
    logic            id_stall, redirect_valid, busy;
    logic [PC_W-1:0] redirect_pc;

    always #5 clk = ~clk;

`ifdef BRANCH_STAT_EN
    logic [STAT_W-1:0] stat_branch, stat_taken, stat_stall;
    branch_ctrl #(.PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_branch(id_branch),
        .id_jump(id_jump), .wait_seg(wait_seg), .realj(realj), .target(target),
        .ex_flush(ex_flush), .if_redirect_ready(if_redirect_ready), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
        .stat_branch(stat_branch), .stat_taken(stat_taken), .stat_stall(stat_stall));
`else
    branch_ctrl #(.PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_branch(id_branch),
        .id_jump(id_jump), .wait_seg(wait_seg), .realj(realj), .target(target),
        .ex_flush(ex_flush), .if_redirect_ready(if_redirect_ready), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy));
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending branch resolves at an absolute cycle number,
    // and a pending redirect is a (flag, address) pair.
    int          cyc = 0;
    bit          m_pend = 0;
    int          m_resolve_at = 0;
    bit          m_redir = 0;
    logic [31:0] m_addr = '0;
    int          m_nbr = 0, m_ntk = 0, m_nst = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit j, input int ws, input bit rj,
                         input logic [31:0] tgt, input bit fl, input bit rdy);
        id_valid = v; id_branch = b; id_jump = j; wait_seg = ws[1:0]; realj = rj;
        target = tgt; ex_flush = fl; if_redirect_ready = rdy;
    endtask

    // One clock: check the combinational stall, advance the model, check registered outputs.
    task automatic step();
        bit br, tk, resolving, exp_stall;
        int ws;
        #1;
        br        = id_valid && id_branch;
        tk        = id_jump || realj;
        ws        = (wait_seg == 2'd3) ? 2 : int'(wait_seg);
        resolving = 0;
        exp_stall = 0;
        if (m_redir) exp_stall = br;
        else if (m_pend) begin
            if (cyc < m_resolve_at) exp_stall = 1;
            else resolving = 1;
        end else if (br) begin
            if (ws == 0) resolving = 1;
            else exp_stall = 1;
        end
        if (ex_flush) exp_stall = 0;
        chk("id_stall", {31'd0, id_stall}, {31'd0, exp_stall});

        if (ex_flush) begin
            m_pend = 0; m_redir = 0;
        end else if (m_redir) begin
            if (if_redirect_ready) m_redir = 0;
        end else if (resolving) begin
            m_pend = 0; m_nbr++;
            if (tk) begin m_ntk++; m_redir = 1; m_addr = target; end
        end else if (!m_pend && br && ws != 0) begin
            m_pend = 1; m_resolve_at = cyc + ws;
        end
        if (exp_stall) m_nst++;
        cyc++;

        @(posedge clk);
        #1;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
        chk("redirect_pc", redirect_pc, m_addr);
        chk("busy", {31'd0, busy}, {31'd0, (m_pend || m_redir)});
`ifdef BRANCH_STAT_EN
        chk("stat_branch", {28'd0, stat_branch}, m_nbr & 32'hF);
        chk("stat_taken", {28'd0, stat_taken}, m_ntk & 32'hF);
        chk("stat_stall", {28'd0, stat_stall}, m_nst & 32'hF);
`endif
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, 0, 32'h0, 0, rdy);
    endtask

    initial begin
        // Reset: outputs quiet even with a waiting branch presented.
        drive(1, 1, 0, 2, 1, 32'hDEAD_BEEF, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        idle(0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Immediate taken branch with fetch ready.
        drive(1, 1, 0, 0, 1, 32'hBFC0_0100, 0, 1); step();
        chk("imm_pc", redirect_pc, 32'hBFC0_0100);
        idle(1); step();
        idle(1); step();

        // EC load-use wait, taken then not taken.
        drive(1, 1, 0, 2, 1, 32'h0040_0200, 0, 1); step(); step(); step();
        idle(1); step(); step();
        drive(1, 1, 0, 2, 0, 32'h0040_0300, 0, 1); step(); step(); step();
        idle(1); step();
        // Illegal code 3 behaves as 2.
        drive(1, 1, 0, 3, 1, 32'h0040_0400, 0, 0); step(); step(); step();
        idle(1); step();

        // Redirect backpressure with a changing target and a delay-slot branch.
        drive(1, 1, 1, 0, 0, 32'h1234_0000, 0, 0); step();
        drive(1, 0, 0, 0, 0, 32'h8000_0000, 0, 0); step();
        drive(1, 1, 0, 1, 1, 32'h8000_0000, 0, 0); step(); step(); step();
        drive(1, 1, 0, 1, 1, 32'h8000_0000, 0, 1); step();
        chk("bp_pc", redirect_pc, 32'h1234_0000);
        step(); step();
        idle(1); step();

        // Flush on the second stall cycle.
        drive(1, 1, 0, 2, 1, 32'h0BAD_0000, 0, 1); step();
        drive(1, 1, 0, 2, 1, 32'h0BAD_0000, 1, 1); step();
        idle(1); step(); step();

        // Flush coinciding with the resolving cycle, then a normal taken branch.
        drive(1, 1, 0, 1, 1, 32'h0BAD_1000, 0, 1); step();
        drive(1, 1, 0, 1, 1, 32'h0BAD_1000, 1, 1); step();
        drive(1, 1, 0, 0, 1, 32'hBFC0_0180, 0, 1); step();
        idle(1); step(); step();

        // Flush cancelling a held redirect.
        drive(1, 1, 1, 0, 0, 32'h0000_3000, 0, 0); step();
        drive(0, 0, 0, 0, 0, 32'h0, 1, 0); step();
        idle(1); step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
